// File: rtl/feeder_pkg.sv
// Shared types and constants for the row chunk feeder.
package feeder_pkg;

    localparam int          WORD_W  = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        HOLD,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/lane_packer.sv
// NI x 32-bit lane staging register: clear to +0.0, write one word to one lane per cycle.
// lanes_nxt exposes the post-write value so a chunk can be captured on its final write.
module lane_packer
    import feeder_pkg::*;
#(
    parameter int NI    = 8,
    parameter int IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WORD_W-1:0]    wr_dat,
    output logic [NI*WORD_W-1:0] lanes,
    output logic [NI*WORD_W-1:0] lanes_nxt
);

    always_comb begin
        lanes_nxt = lanes;
        if (clr) begin
            lanes_nxt = {NI{FP_ZERO}};
        end else if (wr_en) begin
            lanes_nxt[wr_idx*WORD_W +: WORD_W] = wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes <= {NI{FP_ZERO}};
        end else begin
            lanes <= lanes_nxt;
        end
    end

endmodule

// File: rtl/row_chunk_feeder.sv
// Reads row_len words from a sync-read memory and issues zero-padded NI-lane chunks; first chunk
// NI+MEM_LAT+1 cycles after start, chunks spaced >= MIN_GAP. out_ready low parks the chunk in HOLD
// with no further reads. Define CHUNK_COUNT_EN to add the chunk_count output.
module row_chunk_feeder
    import feeder_pkg::*;
#(
    parameter int NI      = 8,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2,
    parameter int MIN_GAP = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      row_len,
    input  logic                 out_ready,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_W-1:0]    mem_rd_data,
    output logic [NI*WORD_W-1:0] adder_row_input,
    output logic                 chunk_valid,
    output logic                 last_chunk,
    output logic                 busy,
`ifdef CHUNK_COUNT_EN
    output logic [ADDR_W:0]      chunk_count,
`endif
    output logic                 done
);

    localparam int IDX_W = (NI > 1) ? $clog2(NI) : 1;
    localparam int CNT_W = $clog2(NI + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    state_t                 state;
    logic [ADDR_W-1:0]      base_r;
    logic [ADDR_W:0]        len_r;
    logic [ADDR_W:0]        elem_idx;
    logic [CNT_W-1:0]       iss_cnt;
    logic [CNT_W-1:0]       ret_cnt;
    logic [MEM_LAT-1:0]     rd_pipe;
    logic [GAP_W-1:0]       gap_cnt;
    logic [NI*WORD_W-1:0]   lanes;
    logic [NI*WORD_W-1:0]   lanes_nxt;

    logic ret_vld;
    logic last_iss;
    logic all_ret;
    logic more;
    logic can_emit;
    logic emit_now;
    logic start_acc;
    logic pack_clr;

    assign ret_vld   = rd_pipe[MEM_LAT-1];
    assign more      = (elem_idx != len_r);
    assign last_iss  = (iss_cnt == CNT_W'(NI - 1)) || ((elem_idx + (ADDR_W+1)'(1)) == len_r);
    assign all_ret   = ret_vld && ((ret_cnt + CNT_W'(1)) == iss_cnt);
    assign can_emit  = (gap_cnt == '0) && out_ready;
    assign start_acc = (state == IDLE) && start;
    assign pack_clr  = start_acc || ((state == EMIT) && more);
    // The final return can be emitted in the same edge it lands, so the chunk register
    // captures lanes_nxt rather than waiting a cycle in HOLD.
    assign emit_now  = can_emit && (((state == WAIT_DATA) && all_ret) || (state == HOLD));

    assign mem_rd_en   = (state == FETCH);
    assign mem_addr    = mem_rd_en ? (base_r + elem_idx[ADDR_W-1:0]) : '0;
    assign chunk_valid = (state == EMIT);
    assign last_chunk  = chunk_valid && !more;
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_r   <= '0;
            len_r    <= '0;
            elem_idx <= '0;
            iss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        len_r    <= row_len;
                        elem_idx <= '0;
                        iss_cnt  <= '0;
                        state    <= (row_len == '0) ? HOLD : FETCH;
                    end
                end
                FETCH: begin
                    elem_idx <= elem_idx + (ADDR_W+1)'(1);
                    iss_cnt  <= iss_cnt + CNT_W'(1);
                    if (last_iss) begin
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (all_ret) begin
                        state <= can_emit ? EMIT : HOLD;
                    end
                end
                HOLD: begin
                    if (can_emit) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    iss_cnt <= '0;
                    state   <= more ? FETCH : DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= '0;
            ret_cnt <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | MEM_LAT'(mem_rd_en);
            if (start_acc || (state == EMIT)) begin
                ret_cnt <= '0;
            end else if (ret_vld) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

    // Cleared on start so a new row is never held back by the previous row's spacing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (start_acc) begin
            gap_cnt <= '0;
        end else if (emit_now) begin
            gap_cnt <= GAP_W'(MIN_GAP - 1);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_row_input <= '0;
        end else if (emit_now) begin
            adder_row_input <= lanes_nxt;
        end
    end

`ifdef CHUNK_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_count <= '0;
        end else if (start_acc) begin
            chunk_count <= '0;
        end else if (chunk_valid) begin
            chunk_count <= chunk_count + (ADDR_W+1)'(1);
        end
    end
`endif

    lane_packer #(
        .NI    (NI),
        .IDX_W (IDX_W)
    ) u_lane_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr),
        .wr_en     (ret_vld),
        .wr_idx    (ret_cnt[IDX_W-1:0]),
        .wr_dat    (mem_rd_data),
        .lanes     (lanes),
        .lanes_nxt (lanes_nxt)
    );

endmodule

// File: doc/row_chunk_feeder.md
Name: row_chunk_feeder

Overview:
- Transmit-side partner of the 8-lane row reduction organizer.
- Reads one matrix/vector row of `row_len` 32-bit IEEE-754 words from a synchronous-read memory and packs them into NI-lane chunks.
- Issues each chunk with a one-cycle strobe (drives the reducer's outsider4), flags the final chunk, and zero-pads the trailing partial chunk.
- Enforces a minimum spacing between chunks so the reducer's accumulate loop never sees overlapping strobes.

Parameters:
NI, 8, lanes per chunk (must match reducer)
ADDR_W, 10, memory address width
MEM_LAT, 2, cycles from mem_rd_en to valid mem_rd_data (>=1)
MIN_GAP, 12, minimum cycles between consecutive chunk_valid pulses (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a row; sampled only in IDLE
base_addr  in  ADDR_W  address of element 0, latched on start
row_len  in  ADDR_W+1  element count, latched on start; 0 allowed
out_ready  in  1  reducer can accept a chunk (reducer's I_am_ready)
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  32  read data, valid MEM_LAT cycles after mem_rd_en
adder_row_input  out  NI*32  packed chunk; lane k = bits [32k+31:32k], lane 0 = lowest address
chunk_valid  out  1  one-cycle chunk strobe
last_chunk  out  1  high with chunk_valid on the final chunk of a row
busy  out  1  row in progress
done  out  1  one-cycle pulse after the final chunk is issued

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0: adder_row_input = 0, chunk_valid/last_chunk/busy/done/mem_rd_en = 0, mem_addr = 0. State goes to IDLE, the in-flight pipe is cleared and all counters are 0.
- Reset mid-row discards partial data; no chunk_valid is emitted for that row.
- States:
  - IDLE: on start=1, latch base/len, set busy=1 next cycle, go to FETCH.
  - FETCH: issue one read per cycle (mem_rd_en=1, mem_addr = base + elem_idx) until min(NI, remaining) reads for this chunk are issued. Unissued lanes are preset to 32'h0 (+0.0).
  - WAIT_DATA: an MEM_LAT-deep valid shift pipe tracks in-flight reads. Each returning word is written to lane = return index within the chunk. When all issued reads have returned, go to HOLD.
  - HOLD: emit when gap_cnt == 0 and out_ready = 1.
  - EMIT: chunk_valid = 1 for exactly one cycle. last_chunk = 1 if no elements remain. gap_cnt loads MIN_GAP-1.
  - After EMIT: if elements remain, go to FETCH; else go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Registers:
  - adder_row_input is registered and holds stable from one chunk_valid until the next.
  - gap_cnt decrements every cycle to 0, independent of state. The first chunk of a row is gated only by out_ready, not by any gap left from the previous row.
- Latency (row_len >= NI, out_ready = 1):
  - start sampled at cycle 0 → reads at cycles 1..NI.
  - chunk_valid at cycle NI+MEM_LAT+1, which is 11 with defaults.
- row_len = 0: no reads are issued. One all-zero chunk is emitted with last_chunk = 1, so the reducer outputs 0.
- row_len not a multiple of NI: the final chunk has lanes [row_len mod NI .. NI-1] = 0.
- start while busy is ignored. start held high re-triggers only after returning to IDLE.
- out_ready low stalls in HOLD indefinitely with no reads issued (single chunk buffer). out_ready may toggle at any time; only its value in HOLD matters.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: CHUNK_COUNT_EN.
- Defined: adds output chunk_count [ADDR_W+1-1:0]. It is cleared on start and incremented on each chunk_valid, and holds its final value after done until the next start. Reset value is 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package feeder_pkg:
  - WORD_W = 32
  - FP_ZERO = 32'h0000_0000
  - state enum {IDLE, FETCH, WAIT_DATA, HOLD, EMIT, DONE}
- Sub-module lane_packer: NI×32 lane register with clear-to-FP_ZERO and a write-word-to-lane-index port. The FSM, read pipe and gap counter stay in the top module.

Test Plan:
- row_len=16, base=0x010, mem[a]=a, out_ready=1:
  - chunk 1 at cycle 11 with lanes 0x10..0x17; chunk 2 exactly 12 cycles later with lanes 0x18..0x1F and last_chunk=1.
  - done pulses the following cycle.
- row_len=5, base=0x3FE:
  - reads hit 0x3FE, 0x3FF, 0x000, 0x001, 0x002 (wrap).
  - single chunk with lanes 5..7 = 0 and last_chunk=1.
- row_len=0: no mem_rd_en ever; one chunk_valid with adder_row_input=0 and last_chunk=1, then done.
- out_ready held 0 for 30 cycles after data is packed:
  - no chunk_valid and no further reads during the stall.
  - chunk emitted the cycle after out_ready rises; data unchanged.
- row_len=24, rst asserted in cycle 15:
  - all outputs 0 immediately (asynchronous); FSM returns to IDLE.
  - a new start with row_len=8 then produces a single correct chunk.
- start pulsed during a busy row: ignored; the chunk count for the row stays 3 for row_len=24. With CHUNK_COUNT_EN defined, chunk_count reads 3 at done.
